// File: rtl/bsg_downstream_out_param.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | bsg_downstream_out_param                                                   |
// | Assembles IO_W chunks into CORE_W words, buffers them in a show-ahead FIFO |
// | and returns one credit token per TOKEN_DECIMATION words consumed.          |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module bsg_downstream_out_param #(
   parameter int IO_W             = 8,
   parameter int CHUNKS           = 4,
   parameter int DEPTH            = 8,
   parameter int TOKEN_DECIMATION = 4,
   parameter int MSB_FIRST        = 0
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           io_valid_in,
   input  logic [IO_W-1:0]                io_data_in,
   input  logic                           core_ready,
   output logic                           core_valid_out,
   output logic [IO_W*CHUNKS-1:0]         core_data_out,
   output logic                           io_token_out,
   output logic [$clog2(DEPTH):0]         occupancy,
   output logic                           overflow
);

   localparam int CORE_W = IO_W * CHUNKS;
   localparam int AW     = $clog2(DEPTH);
   localparam int PW     = AW + 1;
   localparam int CNT_W  = $clog2(CHUNKS);
   localparam int TW     = (TOKEN_DECIMATION > 1) ? $clog2(TOKEN_DECIMATION) : 1;

   localparam logic [CNT_W-1:0] c_LAST_CHUNK = CNT_W'(CHUNKS - 1);
   localparam logic [TW-1:0]    c_LAST_POP   = TW'(TOKEN_DECIMATION - 1);

   logic [CNT_W-1:0]  r_cnt;
   logic [CORE_W-1:0] r_asm;
   logic [CORE_W-1:0] r_mem [DEPTH];
   logic [PW-1:0]     r_wptr;
   logic [PW-1:0]     r_rptr;
   logic [TW-1:0]     r_pcnt;
   logic              r_token;
   logic              r_overflow;

   logic [CNT_W-1:0]  w_slot;
   logic [CORE_W-1:0] w_word;
   logic              w_last;
   logic              w_push;
   logic              w_pop;
   logic              w_empty;
   logic              w_full;
   logic              w_push_ok;
   logic              w_pwrap;

   assign w_slot = (MSB_FIRST != 0) ? (c_LAST_CHUNK - r_cnt) : r_cnt;
   assign w_last = (r_cnt == c_LAST_CHUNK);

   // w_word is the assembly register with the incoming chunk already merged,
   // so the completing chunk is part of the word pushed on the same edge.
   genvar k;
   generate
      for (k = 0; k < CHUNKS; k++) begin : g_slot
         assign w_word[k*IO_W +: IO_W] = (io_valid_in && (w_slot == CNT_W'(k)))
                                         ? io_data_in : r_asm[k*IO_W +: IO_W];
      end
   endgenerate

   assign w_empty   = (r_wptr == r_rptr);
   assign w_full    = (r_wptr[AW-1:0] == r_rptr[AW-1:0]) && (r_wptr[AW] != r_rptr[AW]);
   assign w_push    = io_valid_in && w_last;
   assign w_pop     = !w_empty && core_ready;
   assign w_push_ok = w_push && (!w_full || w_pop);
   assign w_pwrap   = (r_pcnt == c_LAST_POP);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
         r_asm <= '0;
      end else if (io_valid_in) begin
         r_asm <= w_word;
         r_cnt <= w_last ? '0 : (r_cnt + CNT_W'(1));
      end
   end

   // When full with a simultaneous pop, the write index equals the read index;
   // the popped word is consumed combinationally before the edge overwrites it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
         r_wptr     <= '0;
         r_rptr     <= '0;
         r_overflow <= 1'b0;
      end else begin
         if (w_push_ok) begin
            r_mem[r_wptr[AW-1:0]] <= w_word;
            r_wptr                <= r_wptr + PW'(1);
         end
         if (w_pop) begin
            r_rptr <= r_rptr + PW'(1);
         end
         if (w_push && !w_push_ok) begin
            r_overflow <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pcnt  <= '0;
         r_token <= 1'b0;
      end else begin
         r_token <= w_pop && w_pwrap;
         if (w_pop) begin
            r_pcnt <= w_pwrap ? '0 : (r_pcnt + TW'(1));
         end
      end
   end

   assign core_valid_out = !w_empty;
   assign core_data_out  = r_mem[r_rptr[AW-1:0]];
   assign io_token_out   = r_token;
   assign occupancy      = r_wptr - r_rptr;
   assign overflow       = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_bsg_downstream_out_param.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_bsg_downstream_out_param                                                |
// | Directed and random stimulus against a queue-based reference model.        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_bsg_downstream_out_param;

   localparam int IO_W   = 8;
   localparam int CHUNKS = 4;
   localparam int DEPTH  = 4;
   localparam int TD     = 2;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        io_valid_in;
   logic [7:0]  io_data_in;
   logic        core_ready;
   logic        core_valid_out,  core_valid_out_m;
   logic [31:0] core_data_out,   core_data_out_m;
   logic        io_token_out,    io_token_out_m;
   logic [2:0]  occupancy,       occupancy_m;
   logic        overflow,        overflow_m;

   bsg_downstream_out_param #(.IO_W(IO_W), .CHUNKS(CHUNKS), .DEPTH(DEPTH),
      .TOKEN_DECIMATION(TD), .MSB_FIRST(0)) dut (
      .clk(clk), .rst_n(rst_n), .io_valid_in(io_valid_in), .io_data_in(io_data_in),
      .core_ready(core_ready), .core_valid_out(core_valid_out), .core_data_out(core_data_out),
      .io_token_out(io_token_out), .occupancy(occupancy), .overflow(overflow));

   bsg_downstream_out_param #(.IO_W(IO_W), .CHUNKS(CHUNKS), .DEPTH(DEPTH),
      .TOKEN_DECIMATION(TD), .MSB_FIRST(1)) dut_m (
      .clk(clk), .rst_n(rst_n), .io_valid_in(io_valid_in), .io_data_in(io_data_in),
      .core_ready(core_ready), .core_valid_out(core_valid_out_m), .core_data_out(core_data_out_m),
      .io_token_out(io_token_out_m), .occupancy(occupancy_m), .overflow(overflow_m));

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // reference model state
   int          m_cnt;
   logic [7:0]  m_chunk [CHUNKS];
   logic [31:0] q_lsb [$];
   logic [31:0] q_msb [$];
   int          m_popc;
   logic        m_tok;
   logic        m_ovf;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_clear();
      m_cnt  = 0;
      m_popc = 0;
      m_tok  = 1'b0;
      m_ovf  = 1'b0;
      q_lsb.delete();
      q_msb.delete();
      for (int i = 0; i < CHUNKS; i++) m_chunk[i] = 8'h00;
   endtask

   task automatic check_outputs();
      chk("valid", {31'd0, core_valid_out}, {31'd0, q_lsb.size() != 0});
      chk("valid_m", {31'd0, core_valid_out_m}, {31'd0, q_msb.size() != 0});
      if (q_lsb.size() != 0) begin
         chk("data", core_data_out, q_lsb[0]);
         chk("data_m", core_data_out_m, q_msb[0]);
      end
      chk("occupancy", {29'd0, occupancy}, 32'(q_lsb.size()));
      chk("token", {31'd0, io_token_out}, {31'd0, m_tok});
      chk("overflow", {31'd0, overflow}, {31'd0, m_ovf});
   endtask

   // One cycle: drive, check at negedge, advance model across the rising edge.
   task automatic step(input logic v, input logic [7:0] d, input logic r);
      logic        pop;
      logic        push;
      logic        tok_n;
      logic [31:0] wl;
      logic [31:0] wm;
      io_valid_in = v;
      io_data_in  = d;
      core_ready  = r;
      @(negedge clk);
      check_outputs();
      pop   = (q_lsb.size() != 0) && r;
      push  = 1'b0;
      tok_n = 1'b0;
      wl    = 32'd0;
      wm    = 32'd0;
      if (pop) begin
         m_popc++;
         if (m_popc == TD) begin
            m_popc = 0;
            tok_n  = 1'b1;
         end
      end
      if (v) begin
         m_chunk[m_cnt] = d;
         if (m_cnt == CHUNKS - 1) begin
            push = 1'b1;
            for (int i = 0; i < CHUNKS; i++) begin
               wl = wl | (32'(m_chunk[i]) << (8 * i));
               wm = wm | (32'(m_chunk[i]) << (8 * (CHUNKS - 1 - i)));
            end
            m_cnt = 0;
         end else begin
            m_cnt++;
         end
      end
      @(posedge clk);
      if (pop) begin
         void'(q_lsb.pop_front());
         void'(q_msb.pop_front());
      end
      if (push) begin
         if (q_lsb.size() < DEPTH) begin
            q_lsb.push_back(wl);
            q_msb.push_back(wm);
         end else begin
            m_ovf = 1'b1;
         end
      end
      m_tok = tok_n;
      #1;
   endtask

   task automatic do_reset();
      io_valid_in = 1'b0;
      core_ready  = 1'b0;
      rst_n       = 1'b0;
      #1;
      chk("rst_valid", {31'd0, core_valid_out}, 32'd0);
      chk("rst_occ", {29'd0, occupancy}, 32'd0);
      chk("rst_data", core_data_out, 32'd0);
      chk("rst_token", {31'd0, io_token_out}, 32'd0);
      chk("rst_ovf", {31'd0, overflow}, 32'd0);
      model_clear();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic push_word(input logic [31:0] w, input logic r);
      for (int i = 0; i < CHUNKS; i++) step(1'b1, w[8*i +: 8], r);
   endtask

   initial begin
      logic [5:0] pat;
      rst_n       = 1'b0;
      io_valid_in = 1'b0;
      io_data_in  = 8'h00;
      core_ready  = 1'b0;
      model_clear();
      repeat (2) @(posedge clk);
      #1;
      do_reset();

      // basic assembly, both chunk orders
      push_word(32'h44332211, 1'b1);
      chk("asm_lsb", core_data_out, 32'h44332211);
      chk("asm_msb", core_data_out_m, 32'h11223344);
      chk("asm_valid", {31'd0, core_valid_out}, 32'd1);
      step(1'b0, 8'h00, 1'b1);

      // gapped chunks
      step(1'b1, 8'h11, 1'b1);
      step(1'b0, 8'hEE, 1'b1);
      step(1'b1, 8'h22, 1'b1);
      step(1'b0, 8'hEE, 1'b1);
      step(1'b0, 8'hEE, 1'b1);
      step(1'b1, 8'h33, 1'b1);
      step(1'b1, 8'h44, 1'b1);
      chk("gap_lsb", core_data_out, 32'h44332211);
      chk("gap_occ", {29'd0, occupancy}, 32'd1);
      step(1'b0, 8'h00, 1'b1);
      step(1'b0, 8'h00, 1'b1);

      // overflow on fifth word while stalled, then in-order drain
      for (int w = 0; w < 5; w++) push_word(32'hA0B0C0D0 + 32'(w), 1'b0);
      chk("ovf_occ", {29'd0, occupancy}, 32'd4);
      chk("ovf_flag", {31'd0, overflow}, 32'd1);
      for (int i = 0; i < 6; i++) step(1'b0, 8'h00, 1'b1);

      // fifth word completes on a pop cycle: no drop
      do_reset();
      for (int w = 0; w < 4; w++) push_word(32'h10203040 + 32'(w), 1'b0);
      step(1'b1, 8'h55, 1'b0);
      step(1'b1, 8'h66, 1'b0);
      step(1'b1, 8'h77, 1'b0);
      step(1'b1, 8'h88, 1'b1);
      chk("full_pop_occ", {29'd0, occupancy}, 32'd4);
      chk("full_pop_ovf", {31'd0, overflow}, 32'd0);

      // token decimation on a back-to-back drain
      do_reset();
      for (int w = 0; w < 4; w++) push_word(32'hCAFE0000 + 32'(w), 1'b0);
      pat = 6'd0;
      for (int i = 0; i < 6; i++) begin
         step(1'b0, 8'h00, 1'b1);
         pat[i] = io_token_out;
      end
      chk("token_pattern", {26'd0, pat}, 32'b001010);

      // reset mid-word with buffered words
      push_word(32'h01020304, 1'b0);
      push_word(32'h05060708, 1'b0);
      step(1'b1, 8'hF1, 1'b0);
      step(1'b1, 8'hF2, 1'b0);
      do_reset();
      push_word(32'hA4A3A2A1, 1'b0);
      chk("fresh_word", core_data_out, 32'hA4A3A2A1);
      chk("fresh_occ", {29'd0, occupancy}, 32'd1);

      // random traffic with varying backpressure
      for (int seg = 0; seg < 6; seg++) begin
         int rp;
         rp = (seg % 3 == 0) ? 20 : ((seg % 3 == 1) ? 60 : 95);
         for (int i = 0; i < 80; i++) begin
            step(($urandom % 4) != 0, 8'($urandom), ($urandom % 100) < rp);
         end
         if (seg == 3) do_reset();
      end
      for (int i = 0; i < 8; i++) step(1'b0, 8'h00, 1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
